// File: rtl/fetch1_pkg.sv
// Shared front-end constants and the fetch1 state encoding.
package fetch1_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned PACKET_W         = 64;
    localparam int unsigned FETCH_STRIDE     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_e;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] a);
        return a & ~INST_W'(3);
    endfunction

endpackage

// File: rtl/fetch1.sv
// First fetch stage: owns the fetch PC, sequences start-up, prediction,
// stall and redirect, and produces the side-band that travels with each packet.
module fetch1
    import fetch1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              stall_i,
    input  logic              branch_mispred_i,
    input  logic              wasnt_branch_i,
    input  logic [INST_W-1:0] redirect_pc_i,
    input  logic              pred_0_i,
    input  logic              pred_1_i,
    input  logic [INST_W-1:0] pred_target_i,
    output logic [INST_W-1:0] iaddr_o,
    output logic              ireq_o,
    output logic [INST_W-1:0] pc_o,
    output logic              bubble_1_o,
    output logic              pred_0_o,
    output logic              pred_1_o
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] tgt_q, tgt_d;
    logic [INST_W-1:0] pc_out_d;
    logic              ireq_d;
    logic              bubble_1_d;
    logic              pred_0_d;
    logic              pred_1_d;
    logic              redirect_c;

    assign redirect_c = branch_mispred_i | wasnt_branch_i;
    assign iaddr_o    = pc_q;

    // Next-state, next-PC and side-band selection; redirect beats stall and prediction.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        pc_out_d   = pc_o;
        bubble_1_d = 1'b0;
        pred_0_d   = 1'b0;
        pred_1_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect_c) begin
                    tgt_d   = align_word(redirect_pc_i);
                    state_d = REDIR;
                end else begin
                    pc_d    = RESET_PC;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_c) begin
                    tgt_d   = align_word(redirect_pc_i);
                    state_d = REDIR;
                end else if (stall_i) begin
                    bubble_1_d = bubble_1_o;
                    pred_0_d   = pred_0_o;
                    pred_1_d   = pred_1_o;
                end else begin
                    pc_out_d   = pc_q;
                    bubble_1_d = pred_0_i;
                    pred_0_d   = pred_0_i;
                    pred_1_d   = pred_1_i & ~pred_0_i;
                    if (pred_0_i | pred_1_i) begin
                        pc_d = align_word(pred_target_i);
                    end else begin
                        pc_d = pc_q + INST_W'(FETCH_STRIDE);
                    end
                end
            end
            REDIR: begin
                if (redirect_c) begin
                    tgt_d = align_word(redirect_pc_i);
                end else begin
                    pc_d    = tgt_q;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        ireq_d = (state_d == RUN);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            ireq_o     <= 1'b0;
            pc_o       <= '0;
            bubble_1_o <= 1'b0;
            pred_0_o   <= 1'b0;
            pred_1_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            ireq_o     <= ireq_d;
            pc_o       <= pc_out_d;
            bubble_1_o <= bubble_1_d;
            pred_0_o   <= pred_0_d;
            pred_1_o   <= pred_1_d;
        end
    end

endmodule

// File: tb/tb_fetch1.sv
// Self-checking bench for fetch1: scoreboard of expected packet side-band
// plus per-cycle fetch address checks.
module tb_fetch1;

    typedef struct packed {
        logic [31:0] pc;
        logic        b1;
        logic        p0;
        logic        p1;
    } pkt_t;

    logic        clock_i;
    logic        resetn_i;
    logic        stall_i;
    logic        branch_mispred_i;
    logic        wasnt_branch_i;
    logic [31:0] redirect_pc_i;
    logic        pred_0_i;
    logic        pred_1_i;
    logic [31:0] pred_target_i;
    logic [31:0] iaddr_o;
    logic        ireq_o;
    logic [31:0] pc_o;
    logic        bubble_1_o;
    logic        pred_0_o;
    logic        pred_1_o;

    pkt_t sb[$];
    pkt_t exp_p;
    int   n_pass  = 0;
    int   n_total = 0;

    fetch1 #(.RESET_PC(32'h100)) dut (
        .clock_i          (clock_i),
        .resetn_i         (resetn_i),
        .stall_i          (stall_i),
        .branch_mispred_i (branch_mispred_i),
        .wasnt_branch_i   (wasnt_branch_i),
        .redirect_pc_i    (redirect_pc_i),
        .pred_0_i         (pred_0_i),
        .pred_1_i         (pred_1_i),
        .pred_target_i    (pred_target_i),
        .iaddr_o          (iaddr_o),
        .ireq_o           (ireq_o),
        .pc_o             (pc_o),
        .bubble_1_o       (bubble_1_o),
        .pred_0_o         (pred_0_o),
        .pred_1_o         (pred_1_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic clr();
        stall_i          = 1'b0;
        branch_mispred_i = 1'b0;
        wasnt_branch_i   = 1'b0;
        redirect_pc_i    = 32'h0;
        pred_0_i         = 1'b0;
        pred_1_i         = 1'b0;
        pred_target_i    = 32'h0;
    endtask

    // Reset, release before edge 0, return sampling in cycle 1.
    task automatic do_reset();
        resetn_i = 1'b0;
        clr();
        sb.delete();
        @(negedge clock_i);
        @(negedge clock_i);
        resetn_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] ea;
        resetn_i = 1'b0;
        clr();
        @(negedge clock_i);
        @(negedge clock_i);
        n_total++;
        if ({ireq_o, pc_o, bubble_1_o, pred_0_o, pred_1_o} !== 36'h0)
            $display("FAIL reset_outputs got %h want %h", {ireq_o, pc_o, bubble_1_o, pred_0_o, pred_1_o}, 36'h0);
        else n_pass++;
        n_total++;
        if (iaddr_o !== 32'h100) $display("FAIL reset_iaddr got %h want %h", iaddr_o, 32'h100);
        else n_pass++;
        resetn_i = 1'b1;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h100})
            $display("FAIL startup_fetch got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h100});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            ea = 32'h100 + 32'(8 * i);
            sb.push_back('{pc: ea, b1: 1'b0, p0: 1'b0, p1: 1'b0});
            tick();
            exp_p = sb.pop_front();
            n_total++;
            if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
                $display("FAIL seq_packet%0d got %h want %h", i, {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
            else n_pass++;
            n_total++;
            if ({ireq_o, iaddr_o} !== {1'b1, ea + 32'h8})
                $display("FAIL seq_iaddr%0d got %h want %h", i, {ireq_o, iaddr_o}, {1'b1, ea + 32'h8});
            else n_pass++;
        end
    endtask

    task automatic test_pred();
        do_reset();
        sb.push_back('{pc: 32'h100, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL pred_pre_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        // slot 0 taken at 0x108
        pred_0_i = 1'b1; pred_target_i = 32'h400;
        sb.push_back('{pc: 32'h108, b1: 1'b1, p0: 1'b1, p1: 1'b0});
        tick(); clr();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h400}) $display("FAIL pred0_iaddr got %h want %h", iaddr_o, 32'h400);
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL pred0_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        // slot 1 taken alone, misaligned target
        pred_1_i = 1'b1; pred_target_i = 32'h503;
        sb.push_back('{pc: 32'h400, b1: 1'b0, p0: 1'b0, p1: 1'b1});
        tick(); clr();
        n_total++;
        if (iaddr_o !== 32'h500) $display("FAIL pred1_iaddr got %h want %h", iaddr_o, 32'h500);
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL pred1_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        // both slots taken: slot 0 wins, slot 1 prediction suppressed
        pred_0_i = 1'b1; pred_1_i = 1'b1; pred_target_i = 32'h600;
        sb.push_back('{pc: 32'h500, b1: 1'b1, p0: 1'b1, p1: 1'b0});
        tick(); clr();
        n_total++;
        if (iaddr_o !== 32'h600) $display("FAIL pred01_iaddr got %h want %h", iaddr_o, 32'h600);
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL pred01_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        sb.push_back('{pc: 32'h600, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        n_total++;
        if (iaddr_o !== 32'h608) $display("FAIL pred_after_iaddr got %h want %h", iaddr_o, 32'h608);
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL pred_after_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        pred_1_i = 1'b1; pred_target_i = 32'h200;
        sb.push_back('{pc: 32'h100, b1: 1'b0, p0: 1'b0, p1: 1'b1});
        tick(); clr();
        exp_p = sb.pop_front();
        n_total++;
        if ({ireq_o, iaddr_o, pc_o, bubble_1_o, pred_0_o, pred_1_o} !== {1'b1, 32'h200, exp_p})
            $display("FAIL stall_setup got %h want %h", {ireq_o, iaddr_o, pc_o, bubble_1_o, pred_0_o, pred_1_o}, {1'b1, 32'h200, exp_p});
        else n_pass++;
        // prediction during stall must not move the PC
        stall_i = 1'b1; pred_0_i = 1'b1; pred_target_i = 32'h700;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({ireq_o, iaddr_o, pc_o, bubble_1_o, pred_0_o, pred_1_o} !== {1'b1, 32'h200, exp_p})
                $display("FAIL stall_hold%0d got %h want %h", i, {ireq_o, iaddr_o, pc_o, bubble_1_o, pred_0_o, pred_1_o}, {1'b1, 32'h200, exp_p});
            else n_pass++;
        end
        clr();
        sb.push_back('{pc: 32'h200, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        n_total++;
        if (iaddr_o !== 32'h208) $display("FAIL stall_resume_iaddr got %h want %h", iaddr_o, 32'h208);
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL stall_resume_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        sb.push_back('{pc: 32'h100, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        exp_p = sb.pop_front();
        // cycle N: redirect with stall and prediction also asserted
        branch_mispred_i = 1'b1; redirect_pc_i = 32'h80;
        stall_i = 1'b1; pred_0_i = 1'b1; pred_target_i = 32'h400;
        tick(); clr();
        n_total++;
        if ({ireq_o, pc_o, bubble_1_o, pred_0_o, pred_1_o} !== {1'b0, exp_p})
            $display("FAIL redir_n1 got %h want %h", {ireq_o, pc_o, bubble_1_o, pred_0_o, pred_1_o}, {1'b0, exp_p});
        else n_pass++;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h80}) $display("FAIL redir_n2 got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h80});
        else n_pass++;
        sb.push_back('{pc: 32'h80, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL redir_n3_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        n_total++;
        if (iaddr_o !== 32'h88) $display("FAIL redir_n3_iaddr got %h want %h", iaddr_o, 32'h88);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wasnt_branch_i = 1'b1; redirect_pc_i = 32'h40;
        tick(); clr();
        n_total++;
        if (ireq_o !== 1'b0) $display("FAIL b2b_n1 got %b want %b", ireq_o, 1'b0);
        else n_pass++;
        branch_mispred_i = 1'b1; redirect_pc_i = 32'h60;
        tick(); clr();
        n_total++;
        if (ireq_o !== 1'b0) $display("FAIL b2b_n2 got %b want %b", ireq_o, 1'b0);
        else n_pass++;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h60}) $display("FAIL b2b_n3 got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h60});
        else n_pass++;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h68}) $display("FAIL b2b_n4 got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h68});
        else n_pass++;
    endtask

    task automatic test_wrap_align();
        do_reset();
        branch_mispred_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFB;
        tick(); clr(); tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'hFFFF_FFF8})
            $display("FAIL wrap_setup got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'hFFFF_FFF8});
        else n_pass++;
        sb.push_back('{pc: 32'hFFFF_FFF8, b1: 1'b0, p0: 1'b0, p1: 1'b0});
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h0}) $display("FAIL wrap_iaddr got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h0});
        else n_pass++;
        exp_p = sb.pop_front();
        n_total++;
        if ({pc_o, bubble_1_o, pred_0_o, pred_1_o} !== exp_p)
            $display("FAIL wrap_packet got %h want %h", {pc_o, bubble_1_o, pred_0_o, pred_1_o}, exp_p);
        else n_pass++;
        wasnt_branch_i = 1'b1; redirect_pc_i = 32'h13;
        tick(); clr(); tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h10}) $display("FAIL align_iaddr got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h10});
        else n_pass++;
        // reset while in REDIR discards the captured target
        branch_mispred_i = 1'b1; redirect_pc_i = 32'h900;
        tick(); clr();
        #2 resetn_i = 1'b0;
        #1;
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b0, 32'h100}) $display("FAIL async_reset got %h want %h", {ireq_o, iaddr_o}, {1'b0, 32'h100});
        else n_pass++;
        @(negedge clock_i);
        resetn_i = 1'b1;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h100}) $display("FAIL reset_resume0 got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h100});
        else n_pass++;
        tick();
        n_total++;
        if ({ireq_o, iaddr_o} !== {1'b1, 32'h108}) $display("FAIL reset_resume1 got %h want %h", {ireq_o, iaddr_o}, {1'b1, 32'h108});
        else n_pass++;
    endtask

    initial begin
        resetn_i = 1'b0;
        clr();
        test_reset();
        test_pred();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap_align();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
